// File: rtl/div_sequencer_if.sv
// Handshake bundle between decode/write-back and the divide sequencer.
// The master drives requests and flush; the slave returns stall, done and result.
interface div_sequencer_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2, flush,
        input  stall, done, result
    );

    modport slave (
        input  start, op, rs1, rs2, flush,
        output stall, done, result
    );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with pipeline stall.
// Define DIV_SPECIAL_FASTPATH_EN to finish divide-by-zero and signed overflow in one cycle.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    div_sequencer_if.slave  bus
);
    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST     = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] result_q;
    logic            rem_sel;
    logic            quo_neg;
    logic            rem_neg;
    logic            done_q;
`ifndef DIV_SPECIAL_FASTPATH_EN
    logic            special_q;
    logic [XLEN-1:0] special_val_q;
`endif

    logic            accept;
    logic            signed_op;
    logic            special_hit;
    logic [XLEN-1:0] special_value;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] next_quo;
    logic [XLEN-1:0] next_rem;
    logic [XLEN-1:0] final_quo;
    logic [XLEN-1:0] final_rem;
    logic [XLEN-1:0] calc_result;

    assign accept     = bus.start && !bus.flush && (state == IDLE || state == DONE);
    assign bus.stall  = accept || (state == CALC);
    assign bus.done   = done_q;
    assign bus.result = result_q;

    // Operand magnitudes and the architecturally defined answers for the corner cases.
    always_comb begin
        signed_op     = !bus.op[0];
        mag1          = (signed_op && bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
        mag2          = (signed_op && bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;
        special_hit   = 1'b0;
        special_value = '0;
        if (bus.rs2 == '0) begin
            special_hit   = 1'b1;
            special_value = bus.op[1] ? bus.rs1 : ALL_ONES;
        end else if (signed_op && bus.rs1 == INT_MIN && bus.rs2 == ALL_ONES) begin
            special_hit   = 1'b1;
            special_value = bus.op[1] ? '0 : INT_MIN;
        end
    end

    // One restoring step: the trial difference is XLEN+1 bits so its MSB is the borrow.
    always_comb begin
        shifted = {rem, quo[XLEN-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[XLEN]) begin
            next_rem = shifted[XLEN-1:0];
            next_quo = {quo[XLEN-2:0], 1'b0};
        end else begin
            next_rem = trial[XLEN-1:0];
            next_quo = {quo[XLEN-2:0], 1'b1};
        end
        final_quo   = quo_neg ? -next_quo : next_quo;
        final_rem   = rem_neg ? -next_rem : next_rem;
        calc_result = rem_sel ? final_rem : final_quo;
`ifndef DIV_SPECIAL_FASTPATH_EN
        if (special_q) begin
            calc_result = special_val_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            divisor       <= '0;
            quo           <= '0;
            rem           <= '0;
            result_q      <= '0;
            rem_sel       <= 1'b0;
            quo_neg       <= 1'b0;
            rem_neg       <= 1'b0;
            done_q        <= 1'b0;
`ifndef DIV_SPECIAL_FASTPATH_EN
            special_q     <= 1'b0;
            special_val_q <= '0;
`endif
        end else if (bus.flush) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        rem_sel <= bus.op[1];
                        quo_neg <= signed_op && (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
                        rem_neg <= signed_op && bus.rs1[XLEN-1];
                        divisor <= mag2;
                        quo     <= mag1;
                        rem     <= '0;
                        count   <= '0;
`ifdef DIV_SPECIAL_FASTPATH_EN
                        if (special_hit) begin
                            state    <= DONE;
                            done_q   <= 1'b1;
                            result_q <= special_value;
                        end else begin
                            state <= CALC;
                        end
`else
                        special_q     <= special_hit;
                        special_val_q <= special_value;
                        state         <= CALC;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    rem   <= next_rem;
                    quo   <= next_quo;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state    <= DONE;
                        done_q   <= 1'b1;
                        result_q <= calc_result;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: cycle-level scoreboard model plus directed and random ops.
// Honours DIV_SPECIAL_FASTPATH_EN for the expected latency of the special cases.
module tb_div_sequencer;
    localparam int          XLEN     = 32;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;

    div_sequencer_if #(.XLEN(XLEN)) dif ();
    div_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(dif));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    always @(posedge clk) cycle = cycle + 1;

    bit          pending        = 1'b0;
    bit          model_accepted = 1'b0;
    int          accept_cycle   = 0;
    int          done_cycle     = 0;
    logic [31:0] pending_value  = '0;
    logic [31:0] exp_result     = '0;

    // RISC-V divide semantics from plain arithmetic; SV '/' and '%' truncate toward zero.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : ALL_ONES;
        if (!op[0] && a == INT_MIN && b == ALL_ONES) return op[1] ? 32'd0 : INT_MIN;
        case (op)
            2'b00:   return 32'($signed(a) / $signed(b));
            2'b01:   return a / b;
            2'b10:   return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_SPECIAL_FASTPATH_EN
        if (b == 32'd0 || (!op[0] && a == INT_MIN && b == ALL_ONES)) return 1;
`endif
        return 33;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h want %h", name, cycle, got, want);
        end
    endtask

    // Scoreboard: an accepted op completes exactly its latency later unless flushed or reset.
    always @(negedge clk) begin : compare
        bit busy;
        bit exp_done;
        if (rst) begin
            pending        = 1'b0;
            model_accepted = 1'b0;
            exp_result     = '0;
            check_output("reset_stall", 32'(dif.stall), 32'd0);
            check_output("reset_done", 32'(dif.done), 32'd0);
            check_output("reset_result", dif.result, 32'd0);
        end else begin
            exp_done = pending && (cycle == done_cycle);
            if (exp_done) exp_result = pending_value;
            busy = pending && (cycle > accept_cycle) && (cycle < done_cycle);
            check_output("stall", 32'(dif.stall), 32'(busy || (dif.start && !dif.flush)));
            check_output("done", 32'(dif.done), 32'(exp_done));
            check_output("result", dif.result, exp_result);
            model_accepted = 1'b0;
            if (dif.flush) begin
                pending = 1'b0;
            end else if (dif.start && !busy) begin
                pending        = 1'b1;
                model_accepted = 1'b1;
                accept_cycle   = cycle;
                done_cycle     = cycle + exp_latency(dif.op, dif.rs1, dif.rs2);
                pending_value  = ref_result(dif.op, dif.rs1, dif.rs2);
            end
        end
    end

    // Raise start and hold it until the request is taken; returns at posedge+1.
    task automatic apply_stimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int acc);
        bit taken = 1'b0;
        dif.op    = op;
        dif.rs1   = a;
        dif.rs2   = b;
        dif.start = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (model_accepted) begin
                taken = 1'b1;
                break;
            end
        end
        if (!taken) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout at cycle %0d: got none want accept", cycle);
        end
        acc       = accept_cycle;
        dif.start = 1'b0;
    endtask

    task automatic wait_latency(input int acc, input int want, input string name);
        bit seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (dif.done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout at cycle %0d: got no done want done", name, cycle);
        end else begin
            check_output({name, "_latency"}, 32'(cycle - acc), 32'(want));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_directed(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
        int acc;
        apply_stimulus(op, a, b, acc);
        wait_latency(acc, exp_latency(op, a, b), name);
        @(posedge clk);
        #1;
    endtask

    task automatic count_dones(input int ncycles, output int cnt);
        cnt = 0;
        for (int n = 0; n < ncycles; n++) begin
            @(negedge clk);
            if (dif.done) cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout at cycle %0d: got running want finished", cycle);
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int acc;
        int acc2;
        int cnt;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        dif.start = 1'b0;
        dif.flush = 1'b0;
        dif.op    = 2'b00;
        dif.rs1   = '0;
        dif.rs2   = '0;
        rst       = 1'b1;

        check_output("ref_div_m7_2", ref_result(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check_output("ref_rem_m7_2", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check_output("ref_divu_100_7", ref_result(2'b01, 32'd100, 32'd7), 32'd14);
        check_output("ref_remu_100_7", ref_result(2'b11, 32'd100, 32'd7), 32'd2);
        check_output("ref_div_by0", ref_result(2'b00, 32'd5, 32'd0), 32'hFFFF_FFFF);
        check_output("ref_remu_by0", ref_result(2'b11, 32'd5, 32'd0), 32'd5);
        check_output("ref_div_ovf", ref_result(2'b00, INT_MIN, ALL_ONES), 32'h8000_0000);
        check_output("ref_rem_ovf", ref_result(2'b10, INT_MIN, ALL_ONES), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_directed(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_directed(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
        run_directed(2'b00, 32'd5, 32'd0, "div_by0");
        run_directed(2'b11, 32'd5, 32'd0, "remu_by0");
        run_directed(2'b00, INT_MIN, ALL_ONES, "div_ovf");
        run_directed(2'b10, INT_MIN, ALL_ONES, "rem_ovf");
        run_directed(2'b11, 32'd100, 32'd7, "remu_100_7");
        run_directed(2'b01, 32'd100, 32'd7, "divu_100_7");

        // Flush in cycle 10 of a DIVU: no done, result stays at 14.
        apply_stimulus(2'b01, 32'd1000, 32'd3, acc);
        for (int n = 0; n < 50 && cycle < acc + 10; n++) begin
            @(posedge clk);
            #1;
        end
        dif.flush = 1'b1;
        @(posedge clk);
        #1;
        dif.flush = 1'b0;
        count_dones(40, cnt);
        check_output("flush_no_done", 32'(cnt), 32'd0);
        check_output("flush_keeps_result", dif.result, 32'd14);

        dif.op    = 2'b01;
        dif.rs1   = 32'd50;
        dif.rs2   = 32'd5;
        dif.start = 1'b1;
        dif.flush = 1'b1;
        @(posedge clk);
        #1;
        dif.start = 1'b0;
        dif.flush = 1'b0;
        count_dones(40, cnt);
        check_output("flush_start_rejected", 32'(cnt), 32'd0);

        // Reset in the middle of a calculation clears every output at once.
        apply_stimulus(2'b01, 32'd77, 32'd5, acc);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_output("rst_mid_done", 32'(dif.done), 32'd0);
        check_output("rst_mid_stall", 32'(dif.stall), 32'd0);
        check_output("rst_mid_result", dif.result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back: second request raised in the first one's done cycle.
        apply_stimulus(2'b00, 32'hFFFF_FF9C, 32'd7, acc);
        for (int n = 0; n < 100 && cycle < done_cycle; n++) begin
            @(posedge clk);
            #1;
        end
        apply_stimulus(2'b11, 32'd1000, 32'd33, acc2);
        wait_latency(acc2, 33, "b2b");

        for (int i = 0; i < 120; i++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0: begin ra = $urandom; rb = 32'd0; end
                1: begin rop[0] = 1'b0; ra = INT_MIN; rb = ALL_ONES; end
                2: begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 15)); end
                3: begin ra = $urandom; rb = 32'($urandom_range(0, 3)) - 32'd2; end
                default: begin ra = $urandom; rb = $urandom >> $urandom_range(0, 31); end
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            apply_stimulus(rop, ra, rb, acc);
            if ($urandom_range(0, 11) == 0) begin
                repeat ($urandom_range(0, 40)) begin
                    @(posedge clk);
                    #1;
                end
                dif.flush = 1'b1;
                @(posedge clk);
                #1;
                dif.flush = 1'b0;
            end
        end

        for (int n = 0; n < 100 && pending && cycle <= done_cycle; n++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
